// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Bus-readable PWM measurement peripheral. Synchronises an
//               external PWM input and measures its high time and period in
//               clk cycles, from one rising edge to the next. Results,
//               status and control sit behind a sel/wstrb/wdata register bus
//               with a registered read path.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH   counter/result width; longest measurable period is 2^WIDTH-1
// Ports
//   clk     system clock
//   rst     asynchronous, active-high reset
//   sel     peripheral select; bus reads and writes ignored when low
//   wstrb   write strobe (write when sel && wstrb)
//   addr    word register index
//   wdata   write data
//   rdata   registered read data (0 when sel is low)
//   irq     interrupt level valid & irq_mask (PWM_CAPTURE_IRQ_EN only)
//   pwm_in  asynchronous PWM input
// Register map
//   0  high_reg   (RO, zero-extended)
//   1  period_reg (RO, zero-extended)
//   2  status/control: [0] valid (W1C), [1] stuck (W1C), [2] live input
//      level (RO), [3] enable (RW), [4] irq_mask (RW, IRQ build only)
//   3  reads 0
// Build options
//   PWM_CAPTURE_IRQ_EN  when defined, adds the irq output and irq_mask bit
// ============================================================================
module pwm_capture #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        wstrb,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
`ifdef PWM_CAPTURE_IRQ_EN
    output logic        irq,
`endif
    input  logic        pwm_in
);

    localparam logic [WIDTH-1:0] c_cnt_max = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_cnt_one = WIDTH'(1);
    localparam logic [1:0]       c_addr_ctl = 2'd2;

    // ------------------------------------------------------------------
    // Input conditioning: two synchroniser flops plus one delay flop
    // ------------------------------------------------------------------
    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= pwm_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    logic w_rise;
    assign w_rise = r_s2 & ~r_s3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_per_cnt;
    logic [WIDTH-1:0] r_hi_cnt;
    logic [WIDTH-1:0] r_high;
    logic [WIDTH-1:0] r_period;
    logic             r_valid;
    logic             r_stuck;
    logic             r_armed;
    logic             r_enable;
    // Set once a timeout has been reported so a saturated period counter
    // does not keep re-reporting it; cleared by the next rise or disable.
    logic             r_to_done;
    logic [31:0]      r_rdata;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic w_wr_ctl;
    logic w_run;
    logic w_per_sat;
    logic w_hi_sat;
    logic w_latch;
    logic w_timeout;
    logic w_irq_mask;

    assign w_wr_ctl  = sel & wstrb & (addr == c_addr_ctl);
    // A disabling write takes effect in the same cycle it is issued, so it
    // also suppresses a latch on a coincident rise.
    assign w_run     = r_enable & ~(w_wr_ctl & ~wdata[3]);
    assign w_per_sat = (r_per_cnt == c_cnt_max);
    assign w_hi_sat  = (r_hi_cnt == c_cnt_max);
    assign w_latch   = w_run & w_rise & r_armed;
    assign w_timeout = w_run & ~w_rise & w_per_sat & ~r_to_done;

    // ------------------------------------------------------------------
    // Measurement counters and arming
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
            r_armed   <= 1'b0;
            r_to_done <= 1'b0;
        end else if (!w_run) begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
            r_armed   <= 1'b0;
            r_to_done <= 1'b0;
        end else if (w_rise) begin
            // The rise cycle itself is the first cycle of both the new
            // period and the new high phase.
            r_per_cnt <= c_cnt_one;
            r_hi_cnt  <= c_cnt_one;
            r_armed   <= 1'b1;
            r_to_done <= 1'b0;
        end else begin
            if (!w_per_sat) begin
                r_per_cnt <= r_per_cnt + c_cnt_one;
            end
            if (!w_hi_sat) begin
                r_hi_cnt <= r_hi_cnt + WIDTH'(r_s2);
            end
            if (w_timeout) begin
                r_armed   <= 1'b0;
                r_to_done <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_high   <= '0;
            r_period <= '0;
        end else if (w_latch) begin
            r_high   <= r_hi_cnt;
            r_period <= r_per_cnt;
        end else if (w_timeout) begin
            // A stuck input is reported as 100% or 0% duty depending on
            // the level it is stuck at.
            r_high   <= r_s2 ? c_cnt_max : '0;
            r_period <= c_cnt_max;
        end
    end

    // ------------------------------------------------------------------
    // Status and control (hardware set wins over a W1C clear)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_stuck  <= 1'b0;
            r_enable <= 1'b1;
        end else begin
            if (w_latch || w_timeout) begin
                r_valid <= 1'b1;
            end else if (w_wr_ctl && wdata[0]) begin
                r_valid <= 1'b0;
            end

            if (w_timeout) begin
                r_stuck <= 1'b1;
            end else if (w_wr_ctl && wdata[1]) begin
                r_stuck <= 1'b0;
            end

            if (w_wr_ctl) begin
                r_enable <= wdata[3];
            end
        end
    end

`ifdef PWM_CAPTURE_IRQ_EN
    logic r_irq_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_mask <= 1'b0;
        end else if (w_wr_ctl) begin
            r_irq_mask <= wdata[4];
        end
    end

    assign w_irq_mask = r_irq_mask;
    assign irq        = r_valid & r_irq_mask;

    logic w_unused_wdata;
    assign w_unused_wdata = ^{wdata[31:5], wdata[2]};
`else
    assign w_irq_mask = 1'b0;

    logic w_unused_wdata;
    assign w_unused_wdata = ^{wdata[31:4], wdata[2]};
`endif

    // ------------------------------------------------------------------
    // Read path: registered, one cycle of latency, zero when deselected
    // ------------------------------------------------------------------
    logic [31:0] w_status;
    logic [31:0] w_rd_mux;

    assign w_status = {27'd0, w_irq_mask, r_enable, r_s2, r_stuck, r_valid};

    always_comb begin
        w_rd_mux = '0;
        case (addr)
            2'd0:    w_rd_mux = 32'(r_high);
            2'd1:    w_rd_mux = 32'(r_period);
            2'd2:    w_rd_mux = w_status;
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (sel) begin
            r_rdata <= w_rd_mux;
        end else begin
            r_rdata <= '0;
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire
